// File: rtl/timer_ctrl.sv
// Register-mapped sequencer for a single timer: holds shadow and active counts,
// runs IDLE/LOAD/RUN, and turns period-end pulses into a sticky, maskable interrupt.
module timer_ctrl (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        BUS_SEL,
    input  logic        BUS_WR,
    input  logic [2:0]  BUS_ADDR,
    input  logic [31:0] BUS_WDATA,
    output logic [31:0] BUS_RDATA,
    output logic        T_MODE,
    output logic        T_GO_EN,
    output logic [31:0] T_TOT_CNT,
    output logic [31:0] T_DUTY_CNT,
    input  logic        T_IRQ_TRG,
    output logic        IRQ
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_CMD    = 3'd1;
    localparam logic [2:0] A_TOT    = 3'd2;
    localparam logic [2:0] A_DUTY   = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;
    localparam logic [2:0] A_PCNT   = 3'd5;

    state_t      state, state_nxt;
    logic        cfg_mode, irq_en;
    logic [31:0] sh_tot, sh_duty;
    logic [31:0] act_tot, act_duty;
    logic        act_mode;
    logic        pend, upd, err;
    logic [31:0] pcnt;
    logic [31:0] rd_mux;

    logic wr_en, rd_en;
    logic wr_ctrl, wr_cmd, wr_tot, wr_duty, wr_status;
    logic cmd_start, cmd_stop;
    logic shadow_ok, period_end;
    logic start_ok, start_bad;
    logic apply_ok, apply_bad;
    logic busy;

    assign wr_en     = BUS_SEL & BUS_WR;
    assign rd_en     = BUS_SEL & ~BUS_WR;
    assign wr_ctrl   = wr_en && (BUS_ADDR == A_CTRL);
    assign wr_cmd    = wr_en && (BUS_ADDR == A_CMD);
    assign wr_tot    = wr_en && (BUS_ADDR == A_TOT);
    assign wr_duty   = wr_en && (BUS_ADDR == A_DUTY);
    assign wr_status = wr_en && (BUS_ADDR == A_STATUS);

    // STOP dominates a combined START|STOP write
    assign cmd_start = wr_cmd & BUS_WDATA[0] & ~BUS_WDATA[1];
    assign cmd_stop  = wr_cmd & BUS_WDATA[1];

    assign shadow_ok  = (sh_tot != 32'd0) && (sh_duty <= sh_tot);
    assign busy       = (state == S_RUN);
    assign period_end = busy & T_IRQ_TRG;

    // Deferred updates are decided by the UPD value before this cycle's write
    assign apply_ok  = period_end & upd & shadow_ok;
    assign apply_bad = period_end & upd & ~shadow_ok;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        T_GO_EN   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_start) begin
                    if (shadow_ok) begin
                        start_ok  = 1'b1;
                        state_nxt = S_LOAD;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            S_LOAD: state_nxt = S_RUN;
            S_RUN: begin
                T_GO_EN = 1'b1;
                if (cmd_stop || (T_IRQ_TRG && !act_mode)) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cfg_mode <= 1'b0;
            irq_en   <= 1'b0;
            sh_tot   <= '0;
            sh_duty  <= '0;
        end else begin
            if (wr_ctrl) begin
                cfg_mode <= BUS_WDATA[0];
                irq_en   <= BUS_WDATA[1];
            end
            if (wr_tot)  sh_tot  <= BUS_WDATA;
            if (wr_duty) sh_duty <= BUS_WDATA;
        end
    end

    // Active counts are captured on entry to LOAD so they are on the outputs
    // for the whole LOAD cycle; no shadow write can share that edge.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            act_tot  <= '0;
            act_duty <= '0;
            act_mode <= 1'b0;
        end else if (start_ok) begin
            act_tot  <= sh_tot;
            act_duty <= sh_duty;
            act_mode <= cfg_mode;
        end else if (apply_ok) begin
            act_tot  <= sh_tot;
            act_duty <= sh_duty;
        end
    end

    assign T_TOT_CNT  = act_tot;
    assign T_DUTY_CNT = act_duty;
    assign T_MODE     = act_mode;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            upd <= 1'b0;
        end else if (start_ok) begin
            upd <= 1'b0;
        end else begin
            if (period_end & upd)                upd <= 1'b0;
            if (busy && (wr_tot || wr_duty))     upd <= 1'b1;
        end
    end

    // Hardware set beats software W1C for both sticky flags
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pend <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (period_end)                        pend <= 1'b1;
            else if (wr_status && BUS_WDATA[0])    pend <= 1'b0;
            if (start_bad || apply_bad)            err  <= 1'b1;
            else if (wr_status && BUS_WDATA[3])    err  <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)           pcnt <= '0;
        else if (start_ok)   pcnt <= '0;
        else if (period_end) pcnt <= pcnt + 32'd1;
    end

    always_comb begin
        rd_mux = '0;
        case (BUS_ADDR)
            A_CTRL:   rd_mux = {30'd0, irq_en, cfg_mode};
            A_TOT:    rd_mux = sh_tot;
            A_DUTY:   rd_mux = sh_duty;
            A_STATUS: rd_mux = {28'd0, err, upd, busy, pend};
            A_PCNT:   rd_mux = pcnt;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            BUS_RDATA <= '0;
            IRQ       <= 1'b0;
        end else begin
            if (rd_en) BUS_RDATA <= rd_mux;
            IRQ <= pend & irq_en;
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: vector table, directed corner sequences,
// and a randomized phase compared against a behavioural model.
module tb_timer_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        bus_sel = 1'b0, bus_wr = 1'b0;
    logic [2:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        t_mode, t_go_en, t_irq_trg = 1'b0, irq;
    logic [31:0] t_tot_cnt, t_duty_cnt;

    int n_chk = 0;
    int n_pass = 0;

    timer_ctrl dut (
        .CLK(clk), .RSTN(rstn),
        .BUS_SEL(bus_sel), .BUS_WR(bus_wr), .BUS_ADDR(bus_addr),
        .BUS_WDATA(bus_wdata), .BUS_RDATA(bus_rdata),
        .T_MODE(t_mode), .T_GO_EN(t_go_en), .T_TOT_CNT(t_tot_cnt),
        .T_DUTY_CNT(t_duty_cnt), .T_IRQ_TRG(t_irq_trg), .IRQ(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel, wr;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic        trg;
        logic        go;
        logic [31:0] tot, duty;
        logic        mode, irq;
        logic        chk_rd;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Called at a negedge; drives one cycle and returns at the following negedge.
    task automatic cyc(input logic sel, input logic wr, input logic [2:0] addr,
                       input logic [31:0] wd, input logic trg);
        bus_sel = sel; bus_wr = wr; bus_addr = addr; bus_wdata = wd; t_irq_trg = trg;
        @(negedge clk);
        bus_sel = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0; t_irq_trg = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    endtask

    task automatic trg();
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        cyc(1'b1, 1'b0, a, 32'd0, 1'b0);
        chk(name, bus_rdata, exp);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // ---------------- behavioural reference model ----------------
    logic        m_mode, m_en, m_pend, m_upd, m_err, m_amode, m_irq;
    logic [31:0] m_tot, m_duty, m_atot, m_aduty, m_pcnt, m_rdata;
    int          m_stage;  // 0 idle, 1 load, 2 run

    task automatic model_reset();
        m_mode = 0; m_en = 0; m_pend = 0; m_upd = 0; m_err = 0; m_amode = 0; m_irq = 0;
        m_tot = 0; m_duty = 0; m_atot = 0; m_aduty = 0; m_pcnt = 0; m_rdata = 0;
        m_stage = 0;
    endtask

    task automatic model_step(input logic sel, input logic w, input logic [2:0] a,
                              input logic [31:0] wd, input logic t);
        bit we, run, ev, ok, start, stop;
        logic        n_mode, n_en, n_pend, n_upd, n_err, n_amode;
        logic [31:0] n_tot, n_duty, n_atot, n_aduty, n_pcnt;
        int          n_stage;
        we    = sel && w;
        run   = (m_stage == 2);
        ev    = run && t;
        ok    = (m_tot != 0) && (m_duty <= m_tot);
        start = we && a == 1 && wd[0] && !wd[1];
        stop  = we && a == 1 && wd[1];
        n_mode = m_mode; n_en = m_en; n_tot = m_tot; n_duty = m_duty;
        n_pend = m_pend; n_upd = m_upd; n_err = m_err; n_pcnt = m_pcnt;
        n_atot = m_atot; n_aduty = m_aduty; n_amode = m_amode; n_stage = m_stage;
        if (sel && !w) begin
            case (a)
                3'd0: m_rdata = {30'd0, m_en, m_mode};
                3'd2: m_rdata = m_tot;
                3'd3: m_rdata = m_duty;
                3'd4: m_rdata = {28'd0, m_err, m_upd, run, m_pend};
                3'd5: m_rdata = m_pcnt;
                default: m_rdata = 0;
            endcase
        end
        if (we && a == 0) begin n_mode = wd[0]; n_en = wd[1]; end
        if (we && a == 2) n_tot = wd;
        if (we && a == 3) n_duty = wd;
        if (we && a == 4 && wd[0]) n_pend = 0;
        if (we && a == 4 && wd[3]) n_err = 0;
        if (m_stage == 0 && start) begin
            if (ok) begin
                n_stage = 1; n_pcnt = 0; n_upd = 0;
                n_atot = m_tot; n_aduty = m_duty; n_amode = m_mode;
            end else n_err = 1;
        end else if (m_stage == 1) begin
            n_stage = 2;
        end else if (run) begin
            if (ev) begin
                n_pend = 1;
                n_pcnt = m_pcnt + 1;
                if (m_upd) begin
                    n_upd = 0;
                    if (ok) begin n_atot = m_tot; n_aduty = m_duty; end
                    else n_err = 1;
                end
            end
            if (we && (a == 2 || a == 3)) n_upd = 1;
            if (stop || (t && !m_amode)) n_stage = 0;
        end
        m_irq = m_pend & m_en;
        m_mode = n_mode; m_en = n_en; m_tot = n_tot; m_duty = n_duty;
        m_pend = n_pend; m_upd = n_upd; m_err = n_err; m_pcnt = n_pcnt;
        m_atot = n_atot; m_aduty = n_aduty; m_amode = n_amode; m_stage = n_stage;
    endtask

    initial begin
        //           sel wr addr wd   trg go tot duty mode irq chk rd
        vecs[0]  = '{1, 1, 3'd0, 32'd3,   0, 0, 32'd0,   32'd0,  0, 0, 0, 32'd0};
        vecs[1]  = '{1, 1, 3'd2, 32'd100, 0, 0, 32'd0,   32'd0,  0, 0, 0, 32'd0};
        vecs[2]  = '{1, 1, 3'd3, 32'd40,  0, 0, 32'd0,   32'd0,  0, 0, 0, 32'd0};
        vecs[3]  = '{1, 1, 3'd1, 32'd1,   0, 0, 32'd100, 32'd40, 1, 0, 0, 32'd0};
        vecs[4]  = '{0, 0, 3'd0, 32'd0,   0, 1, 32'd100, 32'd40, 1, 0, 0, 32'd0};
        vecs[5]  = '{0, 0, 3'd0, 32'd0,   1, 1, 32'd100, 32'd40, 1, 0, 0, 32'd0};
        vecs[6]  = '{0, 0, 3'd0, 32'd0,   0, 1, 32'd100, 32'd40, 1, 1, 0, 32'd0};
        vecs[7]  = '{0, 0, 3'd0, 32'd0,   1, 1, 32'd100, 32'd40, 1, 1, 0, 32'd0};
        vecs[8]  = '{0, 0, 3'd0, 32'd0,   1, 1, 32'd100, 32'd40, 1, 1, 0, 32'd0};
        vecs[9]  = '{1, 0, 3'd5, 32'd0,   0, 1, 32'd100, 32'd40, 1, 1, 1, 32'd3};
        vecs[10] = '{1, 1, 3'd4, 32'd1,   0, 1, 32'd100, 32'd40, 1, 1, 0, 32'd0};
        vecs[11] = '{0, 0, 3'd0, 32'd0,   0, 1, 32'd100, 32'd40, 1, 0, 0, 32'd0};
        vecs[12] = '{1, 0, 3'd4, 32'd0,   0, 1, 32'd100, 32'd40, 1, 0, 1, 32'd2};
        vecs[13] = '{1, 1, 3'd1, 32'd2,   0, 0, 32'd100, 32'd40, 1, 0, 0, 32'd0};
        vecs[14] = '{1, 0, 3'd4, 32'd0,   0, 0, 32'd100, 32'd40, 1, 0, 1, 32'd0};

        #1;
        chkb("rst_go", t_go_en, 1'b0);
        chk("rst_tot", t_tot_cnt, 32'd0);
        chk("rst_rdata", bus_rdata, 32'd0);
        do_reset();
        chkb("rst_irq", irq, 1'b0);
        chkb("rst_mode", t_mode, 1'b0);

        // periodic run from the vector table
        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].trg);
            chkb($sformatf("vec%0d_go", i), t_go_en, vecs[i].go);
            chk($sformatf("vec%0d_tot", i), t_tot_cnt, vecs[i].tot);
            chk($sformatf("vec%0d_duty", i), t_duty_cnt, vecs[i].duty);
            chkb($sformatf("vec%0d_mode", i), t_mode, vecs[i].mode);
            chkb($sformatf("vec%0d_irq", i), irq, vecs[i].irq);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), bus_rdata, vecs[i].rd);
        end

        // one-shot
        do_reset();
        wr(3'd0, 32'd0); wr(3'd2, 32'd10); wr(3'd3, 32'd5); wr(3'd1, 32'd1);
        idle();
        chkb("os_go_run", t_go_en, 1'b1);
        trg();
        chkb("os_go_end", t_go_en, 1'b0);
        rd_chk("os_status", 3'd4, 32'd1);
        rd_chk("os_pcnt", 3'd5, 32'd1);
        trg();
        rd_chk("os_pcnt_ignored", 3'd5, 32'd1);

        // deferred update, then invalid in-run update
        do_reset();
        wr(3'd0, 32'd1); wr(3'd2, 32'd100); wr(3'd3, 32'd40); wr(3'd1, 32'd1);
        idle();
        wr(3'd2, 32'd200); wr(3'd3, 32'd50);
        rd_chk("upd_status", 3'd4, 32'd6);
        chk("upd_tot_old", t_tot_cnt, 32'd100);
        chk("upd_duty_old", t_duty_cnt, 32'd40);
        trg();
        chk("upd_tot_new", t_tot_cnt, 32'd200);
        chk("upd_duty_new", t_duty_cnt, 32'd50);
        rd_chk("upd_status_clr", 3'd4, 32'd3);
        wr(3'd3, 32'd300);
        trg();
        chk("bad_upd_tot", t_tot_cnt, 32'd200);
        chk("bad_upd_duty", t_duty_cnt, 32'd50);
        rd_chk("bad_upd_status", 3'd4, 32'd11);
        wr(3'd1, 32'd2);
        wr(3'd4, 32'd9);
        rd_chk("w1c_status", 3'd4, 32'd0);

        // invalid START from IDLE
        wr(3'd2, 32'd100); wr(3'd3, 32'd120); wr(3'd1, 32'd1);
        chkb("err_duty_go0", t_go_en, 1'b0);
        idle();
        chkb("err_duty_go1", t_go_en, 1'b0);
        rd_chk("err_duty_status", 3'd4, 32'd8);
        wr(3'd4, 32'd8);
        wr(3'd2, 32'd0); wr(3'd1, 32'd1);
        idle();
        chkb("err_tot0_go", t_go_en, 1'b0);
        rd_chk("err_tot0_status", 3'd4, 32'd8);
        wr(3'd4, 32'd8);

        // collisions
        wr(3'd2, 32'd100); wr(3'd3, 32'd40); wr(3'd1, 32'd1);
        idle();
        cyc(1'b1, 1'b1, 3'd1, 32'd2, 1'b1);
        chkb("stop_trg_go", t_go_en, 1'b0);
        rd_chk("stop_trg_pcnt", 3'd5, 32'd1);
        rd_chk("stop_trg_status", 3'd4, 32'd1);
        wr(3'd4, 32'd1);
        wr(3'd1, 32'd3);
        idle();
        chkb("startstop_go", t_go_en, 1'b0);
        rd_chk("startstop_status", 3'd4, 32'd0);
        wr(3'd1, 32'd1);
        idle();
        cyc(1'b1, 1'b1, 3'd4, 32'd1, 1'b1);
        rd_chk("w1c_trg_status", 3'd4, 32'd3);
        wr(3'd4, 32'd1);
        rd_chk("w1c_only_status", 3'd4, 32'd2);

        // IRQ masking, then asynchronous reset mid-RUN
        do_reset();
        wr(3'd0, 32'd3); wr(3'd2, 32'd100); wr(3'd3, 32'd40); wr(3'd1, 32'd1);
        idle(); trg(); idle();
        chkb("irq_on", irq, 1'b1);
        wr(3'd0, 32'd1);
        idle();
        chkb("irq_masked", irq, 1'b0);
        rd_chk("masked_pend", 3'd4, 32'd3);
        wr(3'd0, 32'd3);
        idle();
        chkb("irq_unmasked", irq, 1'b1);
        rd_chk("pre_rst_pcnt", 3'd5, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chkb("arst_go", t_go_en, 1'b0);
        chkb("arst_irq", irq, 1'b0);
        chkb("arst_mode", t_mode, 1'b0);
        chk("arst_tot", t_tot_cnt, 32'd0);
        chk("arst_duty", t_duty_cnt, 32'd0);
        chk("arst_rdata", bus_rdata, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int a = 0; a < 8; a++) begin
            wr(3'd7, 32'hffff_ffff);
            rd_chk($sformatf("post_rst_reg%0d", a), 3'(a), 32'd0);
        end
        chkb("post_rst_go", t_go_en, 1'b0);

        // randomized phase against the model
        do_reset();
        model_reset();
        for (int i = 0; i < 600; i++) begin
            logic        s, w, t;
            logic [2:0]  a;
            logic [31:0] d;
            s = ($urandom_range(0, 99) < 55);
            w = ($urandom_range(0, 99) < 70);
            a = 3'($urandom_range(0, 7));
            t = ($urandom_range(0, 99) < 25);
            case (a)
                3'd1:    d = 32'($urandom_range(0, 3));
                3'd2:    d = 32'($urandom_range(0, 5));
                3'd3:    d = 32'($urandom_range(0, 6));
                3'd4:    d = 32'($urandom_range(0, 15));
                default: d = $urandom;
            endcase
            model_step(s, w, a, d, t);
            cyc(s, w, a, d, t);
            chkb($sformatf("rnd%0d_go", i), t_go_en, (m_stage == 2));
            chk($sformatf("rnd%0d_tot", i), t_tot_cnt, m_atot);
            chk($sformatf("rnd%0d_duty", i), t_duty_cnt, m_aduty);
            chkb($sformatf("rnd%0d_mode", i), t_mode, m_amode);
            chkb($sformatf("rnd%0d_irq", i), irq, m_irq);
            chk($sformatf("rnd%0d_rdata", i), bus_rdata, m_rdata);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
